// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file write arbiter.
//   ADDR_W_DEF  : default register address width
//   DATA_W_DEF  : default write data width
//   arb_state_t : IDLE / SETUP / COMMIT sequencing states
package regfile_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    COMMIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_wr_sel_decoder.sv
// Enabled one-hot wordline decoder built as a binary tree of 1-to-2 enabled decoders.
// Ports:
//   i_en   : gates every output; all-zero when low
//   i_addr : register address (ADDR_W bits)
//   o_sel  : one-hot wordline select (NREG bits)
module wr_sel_decoder #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREG   = 1 << ADDR_W
) (
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [NREG-1:0]   o_sel
);

  // Heap-ordered tree: node n has children 2n+1 (bit=0) and 2n+2 (bit=1).
  // Leaves occupy NREG-1 .. 2*NREG-2, leaf offset equals the address value.
  logic [2*NREG-2:0] w_node;

  assign w_node[0] = i_en;

  for (genvar k = 0; k < ADDR_W; k++) begin : g_lvl
    for (genvar j = 0; j < (1 << k); j++) begin : g_node
      localparam int unsigned N = (1 << k) - 1 + j;
      // Level k consumes address bit MSB-first.
      assign w_node[2*N+1] = w_node[N] & ~i_addr[ADDR_W-1-k];
      assign w_node[2*N+2] = w_node[N] &  i_addr[ADDR_W-1-k];
    end
  end

  assign o_sel = w_node[2*NREG-2:NREG-1];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the writeback stage
// (req0) and the load-return path (req1). Each accepted write is sequenced SETUP (wordline
// select settles) then COMMIT (write enable fires); COMMIT overlaps the next acceptance.
// Optional feature macro: REGFILE_ARB_ZERO_FILTER_EN -- when defined, writes to address
// NREG-1 (hard-wired zero register) are accepted and dropped without a SETUP/COMMIT.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   i_reqN_valid/addr/data     : requester N write request (N = 0, 1)
//   o_reqN_ready               : requester N accepted this cycle (combinational)
//   o_wr_sel                   : one-hot wordline select, zero when idle
//   o_wr_addr, o_wr_data       : registered address/data of the write in flight
//   o_wr_en                    : write strobe, high only in COMMIT
//   o_busy                     : a write is in flight
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREG   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_data,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req0_ready,
  output logic              o_req1_ready,
  output logic [NREG-1:0]   o_wr_sel,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_wr_en,
  output logic              o_busy
);

  arb_state_t        r_state;
  arb_state_t        w_state_d;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_can_accept;
  logic              w_pick0;
  logic              w_pick1;
  logic              w_accept;
  logic              w_launch;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_data;
  logic              w_busy;

  assign w_can_accept = (r_state == IDLE) || (r_state == COMMIT);

  // On a tie the requester that did not win last time is granted; r_last=1 favours req0.
  assign w_pick0 = i_req0_valid && (!i_req1_valid || r_last);
  assign w_pick1 = i_req1_valid && (!i_req0_valid || !r_last);

  assign o_req0_ready = w_can_accept && w_pick0;
  assign o_req1_ready = w_can_accept && w_pick1;
  assign w_accept     = o_req0_ready || o_req1_ready;

  assign w_acc_addr = o_req1_ready ? i_req1_addr : i_req0_addr;
  assign w_acc_data = o_req1_ready ? i_req1_data : i_req0_data;

`ifdef REGFILE_ARB_ZERO_FILTER_EN
  logic w_zero_hit;
  assign w_zero_hit = (w_acc_addr == ADDR_W'(NREG - 1));
  // Zero-register writes consume the grant but never reach the wordlines.
  assign w_launch   = w_accept && !w_zero_hit;
`else
  assign w_launch   = w_accept;
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    w_state_d = w_launch ? SETUP : IDLE;
      SETUP:   w_state_d = COMMIT;
      COMMIT:  w_state_d = w_launch ? SETUP : IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_last <= o_req1_ready;
      end
      if (w_launch) begin
        r_addr <= w_acc_addr;
        r_data <= w_acc_data;
      end
    end
  end

  assign w_busy    = (r_state != IDLE);
  assign o_busy    = w_busy;
  assign o_wr_en   = (r_state == COMMIT);
  assign o_wr_addr = r_addr;
  assign o_wr_data = r_data;

  wr_sel_decoder #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_wr_sel_decoder (
    .i_en   (w_busy),
    .i_addr (r_addr),
    .o_sel  (o_wr_sel)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a write scoreboard: each expected grant
// pushes the write with the cycle its COMMIT is due; every cycle compares wr_en and, when
// a COMMIT is due, the committed address/data/wordline select.
module tb_regfile_write_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 64;
  localparam int unsigned NR = 32;

  logic          clk;
  logic          rst_n;
  logic          i_req0_valid;
  logic [AW-1:0] i_req0_addr;
  logic [DW-1:0] i_req0_data;
  logic          i_req1_valid;
  logic [AW-1:0] i_req1_addr;
  logic [DW-1:0] i_req1_data;
  logic          o_req0_ready;
  logic          o_req1_ready;
  logic [NR-1:0] o_wr_sel;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          o_wr_en;
  logic          o_busy;

  regfile_write_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .NREG   (NR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req0_valid (i_req0_valid),
    .i_req0_addr  (i_req0_addr),
    .i_req0_data  (i_req0_data),
    .i_req1_valid (i_req1_valid),
    .i_req1_addr  (i_req1_addr),
    .i_req1_data  (i_req1_data),
    .o_req0_ready (o_req0_ready),
    .o_req1_ready (o_req1_ready),
    .o_wr_sel     (o_wr_sel),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_wr_en      (o_wr_en),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  fails  = 0;
  int  cyc    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
`ifdef REGFILE_ARB_ZERO_FILTER_EN
    if (a == 5'd31) return;
`endif
    sb.push_back('{due: cyc + 2, addr: a, data: d});
  endtask

  // Sample at the falling edge: expected readies, then scoreboard-driven wr_en check.
  task automatic tick(input logic e0, input logic e1);
    logic          exp_en;
    logic [NR-1:0] one;
    wr_t           e;
    @(negedge clk);
    chk("req0_ready", {63'd0, o_req0_ready}, {63'd0, e0});
    chk("req1_ready", {63'd0, o_req1_ready}, {63'd0, e1});
    if (e0 && i_req0_valid) push(i_req0_addr, i_req0_data);
    if (e1 && i_req1_valid) push(i_req1_addr, i_req1_data);
    exp_en = (sb.size() > 0) && (sb[0].due == cyc);
    chk("wr_en", {63'd0, o_wr_en}, {63'd0, exp_en});
    if (exp_en) begin
      e   = sb.pop_front();
      one = 1;
      chk("commit_addr", 64'(o_wr_addr), 64'(e.addr));
      chk("commit_data", o_wr_data, e.data);
      chk("commit_sel", 64'(o_wr_sel), 64'(one << e.addr));
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drv(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    i_req0_valid = v0; i_req0_addr = a0; i_req0_data = d0;
    i_req1_valid = v1; i_req1_addr = a1; i_req1_data = d1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    chk("rst_wr_sel", 64'(o_wr_sel), 64'd0);
    chk("rst_wr_addr", 64'(o_wr_addr), 64'd0);
    chk("rst_wr_data", o_wr_data, 64'd0);
    chk("rst_wr_en", {63'd0, o_wr_en}, 64'd0);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_ready0", {63'd0, o_req0_ready}, 64'd0);
    chk("rst_ready1", {63'd0, o_req1_ready}, 64'd0);
    #11 rst_n = 1'b1;
    nxt();
    cyc = 0;

    // Single req0 write: ready, SETUP with wordline 5, COMMIT, back to idle.
    drv(1'b1, 5'd5, 64'hA5, 1'b0, '0, '0);
    tick(1'b1, 1'b0); nxt();
    drv(1'b0, '0, '0, 1'b0, '0, '0);
    tick(1'b0, 1'b0);
    chk("t1_setup_sel", 64'(o_wr_sel), 64'h20);
    chk("t1_setup_busy", {63'd0, o_busy}, 64'd1);
    nxt();
    tick(1'b0, 1'b0); nxt();
    tick(1'b0, 1'b0);
    chk("t1_idle_busy", {63'd0, o_busy}, 64'd0);
    chk("t1_idle_sel", 64'(o_wr_sel), 64'd0);
    nxt();

    // Single req1 write; leaves the pointer favouring req0 for the next tie.
    drv(1'b0, '0, '0, 1'b1, 5'd9, 64'h99);
    tick(1'b0, 1'b1); nxt();
    drv(1'b0, '0, '0, 1'b0, '0, '0);
    tick(1'b0, 1'b0); nxt();
    tick(1'b0, 1'b0); nxt();

    // Both valid continuously: grants 0,1,0,1 every other cycle, commits 1,2,1,2.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) drv(1'b0, '0, '0, 1'b0, '0, '0);
      else drv(1'b1, 5'd1, 64'h1111, 1'b1, 5'd2, 64'h2222);
      tick((i % 4) == 0, (i % 4) == 2);
      nxt();
    end
    tick(1'b0, 1'b0); nxt();
    tick(1'b0, 1'b0); nxt();

    // req1 arrives during SETUP: held off, accepted in COMMIT, next SETUP immediate.
    drv(1'b1, 5'd3, 64'h3333, 1'b0, '0, '0);
    tick(1'b1, 1'b0); nxt();
    drv(1'b0, '0, '0, 1'b1, 5'd4, 64'h4444);
    tick(1'b0, 1'b0); nxt();
    tick(1'b0, 1'b1); nxt();
    drv(1'b0, '0, '0, 1'b0, '0, '0);
    tick(1'b0, 1'b0);
    chk("t3_setup_busy", {63'd0, o_busy}, 64'd1);
    chk("t3_setup_sel", 64'(o_wr_sel), 64'h10);
    nxt();
    tick(1'b0, 1'b0); nxt();
    tick(1'b0, 1'b0); nxt();

    // Reset asserted during COMMIT of addr 7: outputs drop without a clock edge.
    drv(1'b1, 5'd7, 64'h7777, 1'b0, '0, '0);
    tick(1'b1, 1'b0); nxt();
    drv(1'b0, '0, '0, 1'b0, '0, '0);
    tick(1'b0, 1'b0); nxt();
    tick(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_wr_en", {63'd0, o_wr_en}, 64'd0);
    chk("t4_rst_wr_sel", 64'(o_wr_sel), 64'd0);
    chk("t4_rst_busy", {63'd0, o_busy}, 64'd0);
    chk("t4_rst_wr_addr", 64'(o_wr_addr), 64'd0);
    nxt();
    #1 rst_n = 1'b1;
    drv(1'b1, 5'd10, 64'hAAAA, 1'b1, 5'd11, 64'hBBBB);
    tick(1'b1, 1'b0); nxt();
    drv(1'b0, '0, '0, 1'b0, '0, '0);
    tick(1'b0, 1'b0); nxt();
    tick(1'b0, 1'b0); nxt();
    tick(1'b0, 1'b0); nxt();

    // Write to address 31 from req0; afterwards a tie must go to req1.
    drv(1'b1, 5'd31, 64'h3131, 1'b0, '0, '0);
    tick(1'b1, 1'b0); nxt();
`ifdef REGFILE_ARB_ZERO_FILTER_EN
    drv(1'b0, '0, '0, 1'b0, '0, '0);
    tick(1'b0, 1'b0);
    chk("t5_zero_busy", {63'd0, o_busy}, 64'd0);
    chk("t5_zero_sel", 64'(o_wr_sel), 64'd0);
    nxt();
`else
    drv(1'b0, '0, '0, 1'b0, '0, '0);
    tick(1'b0, 1'b0);
    chk("t5_r31_sel", 64'(o_wr_sel), 64'h8000_0000);
    nxt();
    tick(1'b0, 1'b0); nxt();
    tick(1'b0, 1'b0); nxt();
`endif
    drv(1'b1, 5'd12, 64'hCCCC, 1'b1, 5'd13, 64'hDDDD);
    tick(1'b0, 1'b1); nxt();
    drv(1'b0, '0, '0, 1'b0, '0, '0);
    tick(1'b0, 1'b0); nxt();
    tick(1'b0, 1'b0); nxt();
    tick(1'b0, 1'b0); nxt();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
